// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 status codes, instruction/function codes and the E-register bubble.
package y86_pkg;
  localparam int W = 64;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ = 4'h6;
  localparam logic [3:0] I_JXX = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET = 4'h9;
  localparam logic [3:0] I_PUSHQ = 4'hA;
  localparam logic [3:0] I_POPQ = 4'hB;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic [3:0] src_a;
    logic [3:0] src_b;
  } e_ctrl_t;
  function automatic e_ctrl_t bubble_ctrl(input logic [3:0] rnone);
    return '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0, dst_e: rnone, dst_m: rnone, src_a: rnone, src_b: rnone};
  endfunction
endpackage

// File: rtl/y86_alu.sv
// y86_alu: combinational Y86-64 ALU producing the result and its condition flags.
module y86_alu
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   fun,
  output logic [W-1:0] val,
  output logic         zf,
  output logic         sf,
  output logic         of,
  output logic         ok
);
  // result and flags; undefined function codes yield zero and are reported not ok
  always_comb begin
    val = fun == ALU_ADD ? b + a :
          fun == ALU_SUB ? b - a :
          fun == ALU_AND ? b & a :
          fun == ALU_XOR ? b ^ a : '0;
    zf = val == '0;
    sf = val[W-1];
    of = fun == ALU_ADD ? (a[W-1] == b[W-1]) && (val[W-1] != a[W-1]) :
         fun == ALU_SUB ? (a[W-1] != b[W-1]) && (val[W-1] != b[W-1]) : 1'b0;
    ok = fun <= ALU_XOR;
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: Y86-64 E pipeline register, ALU, condition codes and branch/cmov condition.
module execute_stage
  import y86_pkg::*;
#(
  parameter int W = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E_bubble,
  input  logic [2:0]   d_stat,
  input  logic [3:0]   d_icode,
  input  logic [3:0]   d_ifun,
  input  logic [W-1:0] d_valC,
  input  logic [W-1:0] d_valA,
  input  logic [W-1:0] d_valB,
  input  logic [3:0]   d_dstE,
  input  logic [3:0]   d_dstM,
  input  logic [3:0]   d_srcA,
  input  logic [3:0]   d_srcB,
  input  logic [2:0]   m_stat,
  input  logic [2:0]   W_stat,
  output logic [2:0]   E_stat,
  output logic [3:0]   E_icode,
  output logic [3:0]   E_ifun,
  output logic [W-1:0] E_valC,
  output logic [W-1:0] E_valA,
  output logic [W-1:0] E_valB,
  output logic [3:0]   E_dstE,
  output logic [3:0]   E_dstM,
  output logic [3:0]   E_srcA,
  output logic [3:0]   E_srcB,
  output logic [W-1:0] e_valE,
  output logic [3:0]   e_dstE,
  output logic         e_Cnd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of
);
  e_ctrl_t e_ctrl;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0] alu_fun;
  logic alu_zf, alu_sf, alu_of, alu_ok, set_cc, lt;
  assign {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB} = e_ctrl;
  // E register: a bubble overrides the normal capture of decode outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e_ctrl <= bubble_ctrl(RNONE);
      {E_valC, E_valA, E_valB} <= '0;
    end else if (E_bubble) begin
      e_ctrl <= bubble_ctrl(RNONE);
      {E_valC, E_valA, E_valB} <= '0;
    end else begin
      e_ctrl <= '{stat: d_stat, icode: d_icode, ifun: d_ifun, dst_e: d_dstE, dst_m: d_dstM, src_a: d_srcA, src_b: d_srcB};
      {E_valC, E_valA, E_valB} <= {d_valC, d_valA, d_valB};
    end
  // ALU operand and function selection from the instruction held in E
  always_comb begin
    alu_a = E_icode inside {I_RRMOVQ, I_OPQ} ? E_valA :
            E_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ} ? E_valC :
            E_icode inside {I_CALL, I_PUSHQ} ? ~W'(7) :
            E_icode inside {I_RET, I_POPQ} ? W'(8) : '0;
    alu_b = E_icode inside {I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ} ? E_valB : '0;
    alu_fun = E_icode == I_OPQ ? E_ifun : ALU_ADD;
  end
  y86_alu #(.W(W)) u_alu (
    .a(alu_a), .b(alu_b), .fun(alu_fun), .val(e_valE),
    .zf(alu_zf), .sf(alu_sf), .of(alu_of), .ok(alu_ok)
  );
  assign set_cc = E_icode == I_OPQ && alu_ok && m_stat == STAT_AOK && W_stat == STAT_AOK;
  // condition codes: only a valid OPq with no downstream exception writes them
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {cc_zf, cc_sf, cc_of} <= 3'b100;
    else if (set_cc) {cc_zf, cc_sf, cc_of} <= {alu_zf, alu_sf, alu_of};
  // branch/cmov condition from registered flags; a failed cmov writes no register
  always_comb begin
    lt = cc_sf ^ cc_of;
    e_Cnd = E_ifun == 4'd0 ? 1'b1 :
            E_ifun == 4'd1 ? lt | cc_zf :
            E_ifun == 4'd2 ? lt :
            E_ifun == 4'd3 ? cc_zf :
            E_ifun == 4'd4 ? !cc_zf :
            E_ifun == 4'd5 ? !lt :
            E_ifun == 4'd6 ? !lt && !cc_zf : 1'b0;
    e_dstE = E_icode == I_RRMOVQ && !e_Cnd ? RNONE : E_dstE;
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: randomized and directed check of execute_stage against a behavioural model.
module tb_execute_stage;
  logic clk = 1'b0, rst_n = 1'b0, E_bubble = 1'b0;
  logic [2:0] d_stat = 3'd1, m_stat = 3'd1, W_stat = 3'd1;
  logic [3:0] d_icode = 4'h1, d_ifun = 4'h0, d_dstE = 4'hF, d_dstM = 4'hF, d_srcA = 4'hF, d_srcB = 4'hF;
  logic [63:0] d_valC = '0, d_valA = '0, d_valB = '0;
  logic [2:0] E_stat;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB, e_dstE;
  logic [63:0] E_valC, E_valA, E_valB, e_valE;
  logic e_Cnd, cc_zf, cc_sf, cc_of;
  logic [2:0] r_stat;
  logic [3:0] r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB;
  logic [63:0] r_valC, r_valA, r_valB;
  logic r_zf, r_sf, r_of;
  int n_checks = 0, n_fail = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // instruction semantics: what each instruction class computes as valE
  function automatic void ref_exec(input logic [3:0] icode, ifun, input logic [63:0] a, b, c,
                                   output logic [63:0] val, output logic writes_cc, output logic zf, sf, of);
    logic signed [65:0] sa, sb, wide;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    wide = '0;
    of = 1'b0;
    writes_cc = 1'b0;
    case (icode)
      4'h2: val = a;
      4'h3: val = c;
      4'h4, 4'h5: val = b + c;
      4'h8, 4'hA: val = b - 64'd8;
      4'h9, 4'hB: val = b + 64'd8;
      4'h6: begin
        writes_cc = ifun < 4'd4;
        case (ifun)
          4'd0: begin wide = sb + sa; val = wide[63:0]; of = wide != {{2{val[63]}}, val}; end
          4'd1: begin wide = sb - sa; val = wide[63:0]; of = wide != {{2{val[63]}}, val}; end
          4'd2: val = b & a;
          4'd3: val = b ^ a;
          default: val = '0;
        endcase
      end
      default: val = '0;
    endcase
    zf = val == 64'd0;
    sf = val[63];
  endfunction

  function automatic logic ref_cnd(input logic [3:0] ifun, input logic zf, sf, of);
    logic less;
    less = sf != of;
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return less || zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    r_stat = 3'd1; r_icode = 4'h1; r_ifun = 4'h0;
    r_valC = '0; r_valA = '0; r_valB = '0;
    r_dstE = 4'hF; r_dstM = 4'hF; r_srcA = 4'hF; r_srcB = 4'hF;
    {r_zf, r_sf, r_of} = 3'b100;
  endtask

  task automatic compare_all(input string tag);
    logic [63:0] v;
    logic w, z, s, o, c;
    ref_exec(r_icode, r_ifun, r_valA, r_valB, r_valC, v, w, z, s, o);
    c = ref_cnd(r_ifun, r_zf, r_sf, r_of);
    check({tag, "_ctrl"}, {E_stat, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB},
          {r_stat, r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB});
    check({tag, "_vals"}, E_valC ^ {E_valA[31:0], E_valA[63:32]} ^ ~E_valB,
          r_valC ^ {r_valA[31:0], r_valA[63:32]} ^ ~r_valB);
    check({tag, "_valE"}, e_valE, v);
    check({tag, "_cnd"}, e_Cnd, c);
    check({tag, "_dstE"}, e_dstE, (r_icode == 4'h2 && !c) ? 4'hF : r_dstE);
    check({tag, "_cc"}, {cc_zf, cc_sf, cc_of}, {r_zf, r_sf, r_of});
  endtask

  task automatic step(input logic bub, input string tag);
    logic [63:0] v;
    logic w, z, s, o;
    E_bubble = bub;
    @(posedge clk);
    ref_exec(r_icode, r_ifun, r_valA, r_valB, r_valC, v, w, z, s, o);
    if (w && m_stat == 3'd1 && W_stat == 3'd1) {r_zf, r_sf, r_of} = {z, s, o};
    if (bub) model_reset_e();
    else begin
      r_stat = d_stat; r_icode = d_icode; r_ifun = d_ifun;
      r_valC = d_valC; r_valA = d_valA; r_valB = d_valB;
      r_dstE = d_dstE; r_dstM = d_dstM; r_srcA = d_srcA; r_srcB = d_srcB;
    end
    #1;
    E_bubble = 1'b0;
    compare_all(tag);
  endtask

  task automatic model_reset_e();
    logic z, s, o;
    {z, s, o} = {r_zf, r_sf, r_of};
    model_reset();
    {r_zf, r_sf, r_of} = {z, s, o};
  endtask

  task automatic load(input logic [3:0] icode, ifun, input logic [63:0] c, a, b, input logic [3:0] dst);
    d_stat = 3'd1; d_icode = icode; d_ifun = ifun;
    d_valC = c; d_valA = a; d_valB = b;
    d_dstE = dst; d_dstM = 4'($urandom_range(0, 15));
    d_srcA = 4'($urandom_range(0, 15)); d_srcB = 4'($urandom_range(0, 15));
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    model_reset();
    #12;
    compare_all("reset");
    check("reset_cnd_ifun0", e_Cnd, 1'b1);
    rst_n = 1'b1;
    load(4'h6, 4'h1, 64'd0, 64'd12, 64'd10, 4'h3);
    step(1'b0, "sub");
    check("sub_result", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_cc_not_yet", {cc_zf, cc_sf, cc_of}, 3'b100);
    load(4'h2, 4'h1, 64'd0, 64'd77, 64'd0, 4'h5);
    step(1'b0, "cmovle_t");
    check("sub_cc", {cc_zf, cc_sf, cc_of}, 3'b010);
    check("cmovle_taken", {e_Cnd, e_dstE}, {1'b1, 4'h5});
    load(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h6);
    step(1'b0, "addov");
    check("addov_result", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    load(4'h6, 4'h0, 64'd0, 64'd1, 64'd1, 4'h2);
    step(1'b0, "add11");
    check("addov_cc", {cc_zf, cc_sf, cc_of}, 3'b011);
    load(4'h2, 4'h1, 64'd0, 64'd9, 64'd0, 4'h5);
    step(1'b0, "cmovle_nt");
    check("cmovle_not_taken", {e_Cnd, e_dstE}, {1'b0, 4'hF});
    load(4'h6, 4'h3, 64'd0, 64'd5, 64'd5, 4'h7);
    step(1'b0, "xor_adr");
    m_stat = 3'd3;
    load(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    step(1'b0, "adr_hold");
    check("adr_cc_hold", {cc_zf, cc_sf, cc_of}, 3'b000);
    m_stat = 3'd1;
    load(4'h6, 4'h0, 64'd0, 64'd3, 64'd4, 4'h2);
    step(1'b1, "bubble");
    check("bubble_icode", {E_icode, e_dstE}, {4'h1, 4'hF});
    load(4'hA, 4'h0, 64'd0, 64'd0, 64'd254, 4'h4);
    step(1'b0, "push");
    check("push_valE", e_valE, 64'd246);
    load(4'h8, 4'h0, 64'd0, 64'd0, 64'd1000, 4'h4);
    step(1'b0, "call");
    check("call_valE", e_valE, 64'd992);
    load(4'hB, 4'h0, 64'd0, 64'd0, 64'd1000, 4'h4);
    step(1'b0, "pop");
    check("pop_valE", e_valE, 64'd1008);
    load(4'h9, 4'h0, 64'd0, 64'd0, 64'd40, 4'h4);
    step(1'b0, "ret");
    check("ret_valE", e_valE, 64'd48);
    check("stack_cc_hold", {cc_zf, cc_sf, cc_of}, 3'b000);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ic;
      ic = ($urandom_range(0, 2) == 0) ? 4'h6 : 4'($urandom_range(0, 11));
      load(ic, 4'(ic == 4'h6 ? ($urandom_range(0, 7) == 0 ? $urandom_range(4, 15) : $urandom_range(0, 3))
                             : $urandom_range(0, 7)),
           rnd64(), rnd64(), rnd64(), 4'($urandom_range(0, 15)));
      d_stat = 3'($urandom_range(1, 4));
      m_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      step($urandom_range(0, 9) == 0, "rnd");
    end
    m_stat = 3'd1;
    W_stat = 3'd1;
    load(4'h6, 4'h1, 64'd0, 64'd3, 64'd3, 4'h1);
    step(1'b0, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_no_cc_write", {cc_zf, cc_sf, cc_of}, 3'b100);
    for (int i = 0; i < 20; i++) begin
      load(4'($urandom_range(2, 11)), 4'($urandom_range(0, 3)), rnd64(), rnd64(), rnd64(), 4'($urandom_range(0, 15)));
      step(1'b0, "post_rst");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
